// File: rtl/wb_byte_fifo.sv
// Byte FIFO with a valid/ready push port and a strobe/ack read port for the CPU.
// A data read pops one byte. A status read returns the sticky overflow flag and the fill level.
module wb_byte_fifo #(
  parameter int AW = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wb_sel,
  input  logic       i_wb_stb,
  output logic [9:0] o_wb_rdt,
  output logic       o_wb_ack,
  input  logic [7:0] i_tdata,
  input  logic       i_tvalid,
  output logic       o_tready
);

  localparam int            DEPTH    = 2 ** AW;
  localparam logic [AW:0]   LVL_FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          ack_q, ack_d;
  logic [9:0]    rdt_q, rdt_d;

  logic full, empty, push, pop, accept, status_rd;
  logic [8:0] level_ext;

  always_comb begin
    full      = (level_q == LVL_FULL);
    empty     = (level_q == '0);
    push      = i_tvalid & ~full;
    accept    = i_wb_stb & ~ack_q;
    pop       = accept & i_wb_sel & ~empty;
    status_rd = accept & ~i_wb_sel;
    level_ext = 9'(level_q);

    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end

    // A drop on the same edge as a status read keeps the flag set.
    ovf_d = ovf_q;
    if (i_tvalid && full) begin
      ovf_d = 1'b1;
    end else if (status_rd) begin
      ovf_d = 1'b0;
    end

    ack_d = accept;

    rdt_d = rdt_q;
    if (accept) begin
      if (!i_wb_sel) begin
        rdt_d = {ovf_q, level_ext};
      end else if (!empty) begin
        rdt_d = {2'b01, mem_q[rd_ptr_q]};
      end else begin
        rdt_d = 10'h000;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdt_q    <= 10'h000;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      ack_q    <= ack_d;
      rdt_q    <= rdt_d;
    end
  end

  // Storage needs no reset; only slots behind wr_ptr are ever read.
  always_ff @(posedge i_clk) begin
    if (!i_rst && push) begin
      mem_q[wr_ptr_q] <= i_tdata;
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_tready = ~full;

endmodule

// File: tb/tb_wb_byte_fifo.sv
// Self-checking bench for wb_byte_fifo: directed scenarios plus random traffic against a queue model.
module tb_wb_byte_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_wb_sel = 1'b0;
  logic       i_wb_stb = 1'b0;
  logic [9:0] o_wb_rdt;
  logic       o_wb_ack;
  logic [7:0] i_tdata = 8'h00;
  logic       i_tvalid = 1'b0;
  logic       o_tready;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: byte queue, sticky overflow, ack and read-data registers.
  logic [7:0] m_q[$];
  logic       m_ovf = 1'b0;
  logic       m_ack = 1'b0;
  logic [9:0] m_rdt = 10'h000;

  wb_byte_fifo #(.AW(AW)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wb_sel (i_wb_sel),
    .i_wb_stb (i_wb_stb),
    .o_wb_rdt (o_wb_rdt),
    .o_wb_ack (o_wb_ack),
    .i_tdata  (i_tdata),
    .i_tvalid (i_tvalid),
    .o_tready (o_tready)
  );

  always #5 i_clk = ~i_clk;

  task automatic model_clear();
    m_q.delete();
    m_ovf = 1'b0;
    m_ack = 1'b0;
    m_rdt = 10'h000;
  endtask

  // Drive one cycle of inputs, advance the model by one edge, then wait past the edge.
  task automatic step(input logic stb, input logic sel, input logic tv, input logic [7:0] td);
    int  pre;
    bit  acc;
    bit  do_pop;
    i_wb_stb = stb;
    i_wb_sel = sel;
    i_tvalid = tv;
    i_tdata  = td;
    pre    = m_q.size();
    acc    = stb && !m_ack;
    do_pop = acc && sel && (pre > 0);
    if (acc) begin
      if (!sel)         m_rdt = {m_ovf, 9'(pre)};
      else if (pre > 0) m_rdt = {2'b01, m_q[0]};
      else              m_rdt = 10'h000;
    end
    if (tv && pre == DEPTH) m_ovf = 1'b1;
    else if (acc && !sel)   m_ovf = 1'b0;
    if (do_pop) void'(m_q.pop_front());
    if (tv && pre < DEPTH) m_q.push_back(td);
    m_ack = acc;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst    = 1'b1;
    i_wb_stb = 1'b0;
    i_wb_sel = 1'b0;
    i_tvalid = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    model_clear();
  endtask

  // One request cycle followed by the ack cycle; returns what was seen in the ack cycle.
  task automatic bus_read(input logic sel, output logic ack_o, output logic [9:0] rdt_o);
    step(1'b1, sel, 1'b0, 8'h00);
    ack_o = o_wb_ack;
    rdt_o = o_wb_rdt;
    step(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    logic       a;
    logic [9:0] r;
    do_reset();
    n_tests++;
    if (o_wb_ack !== 1'b0 || o_wb_rdt !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b rdt=%h, need ack=0 rdt=000", o_wb_ack, o_wb_rdt);
    end
    n_tests++;
    if (o_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tready: got %b, need 1", o_tready);
    end
    i_wb_stb = 1'b1;
    i_wb_sel = 1'b0;
    #1;
    n_tests++;
    if (o_wb_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack_early: got %b, need 0 in request cycle", o_wb_ack);
    end
    step(1'b1, 1'b0, 1'b0, 8'h00);
    a = o_wb_ack;
    r = o_wb_rdt;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    n_tests++;
    if (a !== 1'b1 || r !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_status: ack=%b rdt=%h, need ack=1 rdt=000", a, r);
    end
    n_tests++;
    if (o_wb_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ack_drop: got %b, need 0", o_wb_ack);
    end
  endtask

  task automatic test_basic();
    logic       a;
    logic [9:0] r;
    logic [9:0] exp_rd[4];
    exp_rd[0] = 10'h141;
    exp_rd[1] = 10'h142;
    exp_rd[2] = 10'h143;
    exp_rd[3] = 10'h000;
    step(1'b0, 1'b0, 1'b1, 8'h41);
    step(1'b0, 1'b0, 1'b1, 8'h42);
    step(1'b0, 1'b0, 1'b1, 8'h43);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      bus_read(1'b1, a, r);
      n_tests++;
      if (a !== 1'b1 || r !== exp_rd[i] || r !== m_rdt) begin
        n_fail++;
        $display("FAIL basic_pop%0d: ack=%b rdt=%h, need ack=1 rdt=%h", i, a, r, exp_rd[i]);
      end
    end
    bus_read(1'b0, a, r);
    n_tests++;
    if (a !== 1'b1 || r !== 10'h000) begin
      n_fail++;
      $display("FAIL basic_status: ack=%b rdt=%h, need ack=1 rdt=000", a, r);
    end
  endtask

  task automatic test_overflow();
    logic       a;
    logic [9:0] r;
    for (int i = 0; i < 17; i++) begin
      step(1'b0, 1'b0, 1'b1, 8'(i));
      if (i == 14 || i == 15) begin
        n_tests++;
        if (o_tready !== (i == 14)) begin
          n_fail++;
          $display("FAIL ovf_tready_after_push%0d: got %b, need %b", i + 1, o_tready, (i == 14));
        end
      end
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    bus_read(1'b0, a, r);
    n_tests++;
    if (a !== 1'b1 || r !== 10'h210) begin
      n_fail++;
      $display("FAIL ovf_status1: ack=%b rdt=%h, need ack=1 rdt=210", a, r);
    end
    bus_read(1'b0, a, r);
    n_tests++;
    if (a !== 1'b1 || r !== 10'h010) begin
      n_fail++;
      $display("FAIL ovf_status2: ack=%b rdt=%h, need ack=1 rdt=010", a, r);
    end
    for (int i = 0; i < 16; i++) begin
      bus_read(1'b1, a, r);
      n_tests++;
      if (a !== 1'b1 || r !== (10'h100 + 10'(i))) begin
        n_fail++;
        $display("FAIL ovf_pop%0d: ack=%b rdt=%h, need ack=1 rdt=%h", i, a, r, 10'h100 + 10'(i));
      end
    end
    n_tests++;
    if (o_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_tready_drained: got %b, need 1", o_tready);
    end
  endtask

  task automatic test_wrap();
    logic       a;
    logic [9:0] r;
    logic [7:0] d0, d1;
    int         bad;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      d0 = 8'($urandom);
      d1 = 8'($urandom);
      step(1'b0, 1'b0, 1'b1, d0);
      // Pop and push on the same edge; level must stay at 1.
      step(1'b1, 1'b1, 1'b1, d1);
      if (o_wb_ack !== 1'b1 || o_wb_rdt !== {2'b01, d0} || o_wb_rdt !== m_rdt) begin
        bad++;
        if (bad < 4) $display("FAIL wrap_same_edge%0d: rdt=%h, need %h", i, o_wb_rdt, {2'b01, d0});
      end
      step(1'b0, 1'b0, 1'b0, 8'h00);
      bus_read(1'b0, a, r);
      if (a !== 1'b1 || r !== 10'h001) begin
        bad++;
        if (bad < 4) $display("FAIL wrap_level%0d: rdt=%h, need 001", i, r);
      end
      bus_read(1'b1, a, r);
      if (a !== 1'b1 || r !== {2'b01, d1}) begin
        bad++;
        if (bad < 4) $display("FAIL wrap_pop%0d: rdt=%h, need %h", i, r, {2'b01, d1});
      end
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wrap_sequence: %0d bad cycles, need 0", bad);
    end
    bus_read(1'b0, a, r);
    n_tests++;
    if (a !== 1'b1 || r !== 10'h000) begin
      n_fail++;
      $display("FAIL wrap_final_status: rdt=%h, need 000", r);
    end
  endtask

  task automatic test_held_stb();
    logic       a;
    logic [9:0] r;
    logic [5:0] seen;
    logic [9:0] pops[3];
    int         k;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i));
    i_wb_stb = 1'b1;
    i_wb_sel = 1'b1;
    #1;
    seen[0] = o_wb_ack;
    k = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'h00);
      if (i <= 5) seen[i] = o_wb_ack;
      if (o_wb_ack === 1'b1 && k < 3) begin
        pops[k] = o_wb_rdt;
        k++;
      end
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    n_tests++;
    if (seen !== 6'b101010) begin
      n_fail++;
      $display("FAIL held_ack_pattern: got %b (cycle0 at lsb), need 101010", seen);
    end
    n_tests++;
    if (k != 3 || pops[0] !== 10'h1A0 || pops[1] !== 10'h1A1 || pops[2] !== 10'h1A2) begin
      n_fail++;
      $display("FAIL held_pop_data: %0d acks, got %h %h %h, need 1a0 1a1 1a2", k, pops[0], pops[1], pops[2]);
    end
    bus_read(1'b0, a, r);
    n_tests++;
    if (a !== 1'b1 || r !== 10'h002) begin
      n_fail++;
      $display("FAIL held_level: rdt=%h, need 002", r);
    end
    do_reset();
  endtask

  task automatic test_reset_midreq();
    logic       a;
    logic [9:0] r;
    step(1'b0, 1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b0, 1'b1, 8'h22);
    // Reset on the same edge as a request: the request is dropped.
    i_rst    = 1'b1;
    i_wb_stb = 1'b1;
    i_wb_sel = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst    = 1'b0;
    i_wb_stb = 1'b0;
    model_clear();
    n_tests++;
    if (o_wb_ack !== 1'b0 || o_wb_rdt !== 10'h000 || o_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstreq_same_edge: ack=%b rdt=%h tready=%b, need 0 000 1", o_wb_ack, o_wb_rdt, o_tready);
    end
    bus_read(1'b1, a, r);
    n_tests++;
    if (a !== 1'b1 || r !== 10'h000) begin
      n_fail++;
      $display("FAIL rstreq_pop_after: ack=%b rdt=%h, need 1 000", a, r);
    end
    step(1'b0, 1'b0, 1'b1, 8'h33);
    step(1'b0, 1'b0, 1'b1, 8'h44);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    n_tests++;
    if (o_wb_ack !== 1'b1 || o_wb_rdt !== 10'h133) begin
      n_fail++;
      $display("FAIL rstreq_accept: ack=%b rdt=%h, need 1 133", o_wb_ack, o_wb_rdt);
    end
    // Reset in the ack cycle while the master raises a new request.
    i_rst    = 1'b1;
    i_wb_stb = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst    = 1'b0;
    i_wb_stb = 1'b0;
    model_clear();
    n_tests++;
    if (o_wb_ack !== 1'b0 || o_wb_rdt !== 10'h000) begin
      n_fail++;
      $display("FAIL rstreq_after_accept: ack=%b rdt=%h, need 0 000", o_wb_ack, o_wb_rdt);
    end
    bus_read(1'b0, a, r);
    n_tests++;
    if (a !== 1'b1 || r !== 10'h000) begin
      n_fail++;
      $display("FAIL rstreq_level: rdt=%h, need 000", r);
    end
    bus_read(1'b1, a, r);
    n_tests++;
    if (a !== 1'b1 || r !== 10'h000) begin
      n_fail++;
      $display("FAIL rstreq_pop_empty: rdt=%h, need 000", r);
    end
  endtask

  task automatic test_random();
    int bad_ack, bad_rdt, bad_rdy;
    bad_ack = 0;
    bad_rdt = 0;
    bad_rdy = 0;
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 40), ($urandom_range(99) < 60),
           ($urandom_range(99) < (i < 300 ? 70 : 35)), 8'($urandom));
      if (o_wb_ack !== m_ack) begin
        bad_ack++;
        if (bad_ack < 4) $display("FAIL rand_ack cycle %0d: got %b, need %b", i, o_wb_ack, m_ack);
      end
      if (m_ack && o_wb_rdt !== m_rdt) begin
        bad_rdt++;
        if (bad_rdt < 4) $display("FAIL rand_rdt cycle %0d: got %h, need %h", i, o_wb_rdt, m_rdt);
      end
      if (o_tready !== (m_q.size() < DEPTH)) begin
        bad_rdy++;
        if (bad_rdy < 4) $display("FAIL rand_tready cycle %0d: got %b, need %b", i, o_tready, (m_q.size() < DEPTH));
      end
    end
    n_tests++;
    if (bad_ack != 0) begin
      n_fail++;
      $display("FAIL rand_ack_total: %0d bad, need 0", bad_ack);
    end
    n_tests++;
    if (bad_rdt != 0) begin
      n_fail++;
      $display("FAIL rand_rdt_total: %0d bad, need 0", bad_rdt);
    end
    n_tests++;
    if (bad_rdy != 0) begin
      n_fail++;
      $display("FAIL rand_tready_total: %0d bad, need 0", bad_rdy);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_wrap();
    test_held_stb();
    test_reset_midreq();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
